// File: rtl/shift_register_universal.sv
// Parametrised universal shift register with shift counter and word-done framing.
// Replaces the fixed SISO/SIPO/PISO/PIPO variants with one mode-selected datapath.
module shift_register_universal #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             serial_in_left,
  input  logic             serial_in_right,
  output logic [WIDTH-1:0] parallel_out,
  output logic             serial_out_msb,
  output logic             serial_out_lsb,
  output logic [CW-1:0]    shift_count,
  output logic             word_done
);

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_SHL   = 3'b001;
  localparam logic [2:0] MODE_SHR   = 3'b010;
  localparam logic [2:0] MODE_ASR   = 3'b011;
  localparam logic [2:0] MODE_ROL   = 3'b100;
  localparam logic [2:0] MODE_ROR   = 3'b101;
  localparam logic [2:0] MODE_LOAD  = 3'b110;
  localparam logic [2:0] MODE_CLEAR = 3'b111;

  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             is_shift;

  // Next register value, frame counter and word-done pulse
  always_comb begin
    r_d      = r_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    is_shift = 1'b0;
    if (enable) begin
      case (mode)
        MODE_HOLD:  r_d = r_q;
        MODE_SHL:   begin r_d = {r_q[WIDTH-2:0], serial_in_right}; is_shift = 1'b1; end
        MODE_SHR:   begin r_d = {serial_in_left, r_q[WIDTH-1:1]};  is_shift = 1'b1; end
        MODE_ASR:   begin r_d = {r_q[WIDTH-1], r_q[WIDTH-1:1]};    is_shift = 1'b1; end
        MODE_ROL:   begin r_d = {r_q[WIDTH-2:0], r_q[WIDTH-1]};    is_shift = 1'b1; end
        MODE_ROR:   begin r_d = {r_q[0], r_q[WIDTH-1:1]};          is_shift = 1'b1; end
        MODE_LOAD:  begin r_d = parallel_in; cnt_d = '0; end
        MODE_CLEAR: begin r_d = '0;          cnt_d = '0; end
        default:    r_d = r_q;
      endcase
      // Pulse only on the transition into saturation, never while held there
      if (is_shift) begin
        if (cnt_q != CNT_FULL) cnt_d = cnt_q + CW'(1);
        done_d = (cnt_q == CNT_LAST);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q    <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      r_q    <= r_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign parallel_out   = r_q;
  assign serial_out_msb = r_q[WIDTH-1];
  assign serial_out_lsb = r_q[0];
  assign shift_count    = cnt_q;
  assign word_done      = done_q;

endmodule
